// File: rtl/memory_byte_reader_if.sv
// Bus bundle for memory_byte_reader.
//   start/start_addr/byte_count : transfer request (host -> reader)
//   busy/done                   : transfer status (reader -> host)
//   mem_address/ramOut          : shared word address out, four bank q words in
//   m_data/m_valid/m_ready      : outgoing byte stream, valid/ready handshake
// slave  = the reader side, master = host/RAM/consumer side.
interface memory_byte_reader_if;
  logic             start;
  logic [15:0]      start_addr;
  logic [15:0]      byte_count;
  logic             busy;
  logic             done;
  logic [12:0]      mem_address;
  logic [3:0][15:0] ramOut;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready;

  modport slave (
    input  start, start_addr, byte_count, ramOut, m_ready,
    output busy, done, mem_address, m_data, m_valid
  );

  modport master (
    output start, start_addr, byte_count, ramOut, m_ready,
    input  busy, done, mem_address, m_data, m_valid
  );
endinterface

// File: rtl/memory_byte_reader.sv
// Byte-stream reader for the four 16K-byte RAM banks.
// Reads 16-bit words (bank = addr[15:14], word = addr[13:1]) and emits them
// low byte first (addr[0]=0 -> [7:0], 1 -> [15:8]) on a valid/ready stream.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : memory_byte_reader_if.slave (request, status, RAM, byte stream)
//
// state | meaning
// IDLE  | waiting for start
// READ  | word address driven, waiting out RAM latency, then capture word
// SEND  | presenting one byte of the captured word
// DONE  | one-cycle done pulse, then back to IDLE
module memory_byte_reader #(
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_byte_reader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  // Wait counter is loaded with READ_LATENCY and counts down to zero, giving
  // READ_LATENCY+1 cycles in READ: one for the RAM to latch mem_address, then
  // READ_LATENCY for q to become valid.
  localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY);

  state_t      state, next_state;
  logic [15:0] addr;
  logic [15:0] remaining;
  logic [15:0] word_reg;
  logic [1:0]  wait_cnt;
  logic [12:0] mem_addr_reg;
  logic [15:0] addr_inc;

  logic        accept;
  logic        handshake;
  logic        capture;
  logic        reread;
  logic        busy_c;
  logic        done_c;
  logic        valid_c;
  logic [7:0]  data_c;

  assign addr_inc = addr + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    handshake  = 1'b0;
    capture    = 1'b0;
    reread     = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    valid_c    = 1'b0;
    data_c     = 8'h00;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.byte_count != 16'd0) begin
            accept     = 1'b1;
            next_state = READ;
          end else begin
            next_state = DONE;
          end
        end
      end
      READ: begin
        busy_c = 1'b1;
        if (wait_cnt == 2'd0) begin
          capture    = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        busy_c  = 1'b1;
        valid_c = 1'b1;
        data_c  = addr[0] ? word_reg[15:8] : word_reg[7:0];
        if (bus.m_ready) begin
          handshake = 1'b1;
          if (remaining == 16'd1) begin
            next_state = DONE;
          end else if (addr[0]) begin
            // High byte consumed: next byte lives in the next word, which may
            // also be in the next bank (or wrap from bank 3 to bank 0).
            reread     = 1'b1;
            next_state = READ;
          end
        end
      end
      DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // mem_address is registered and loaded on entry to READ so it is already
  // stable during the first READ cycle; it holds its value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr         <= 16'h0000;
      remaining    <= 16'h0000;
      word_reg     <= 16'h0000;
      wait_cnt     <= 2'd0;
      mem_addr_reg <= 13'h0000;
    end else begin
      if (accept) begin
        addr         <= bus.start_addr;
        remaining    <= bus.byte_count;
        mem_addr_reg <= bus.start_addr[13:1];
        wait_cnt     <= WAIT_LOAD;
      end
      if (state == READ) begin
        if (capture) word_reg <= bus.ramOut[addr[15:14]];
        else         wait_cnt <= wait_cnt - 2'd1;
      end
      if (handshake) begin
        addr      <= addr_inc;
        remaining <= remaining - 16'd1;
      end
      if (reread) begin
        mem_addr_reg <= addr_inc[13:1];
        wait_cnt     <= WAIT_LOAD;
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.m_valid     = valid_c;
  assign bus.m_data      = data_c;
  assign bus.mem_address = mem_addr_reg;

endmodule

// File: tb/tb_memory_byte_reader.sv
// Self-checking bench for memory_byte_reader: directed scenarios plus
// randomized transfers checked against a byte-address reference model.
module tb_memory_byte_reader;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_byte_reader_if bus();

  memory_byte_reader #(.READ_LATENCY(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: q valid RL edges after the address is latched (RL=1 here).
  logic [15:0] mem [0:3][0:8191];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) bus.ramOut[b] <= mem[b][bus.mem_address];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int r_first_v, r_done_n, r_done_c, r_last_hs, r_reads, r_hold_err;

  function automatic logic [7:0] exp_byte(input logic [15:0] a);
    logic [15:0] w;
    w = mem[a[15:14]][a[13:1]];
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic void build_exp(input logic [15:0] a, input int n);
    logic [15:0] b;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      b = a + 16'(i);
      exp_q.push_back(exp_byte(b));
    end
  endfunction

  // One word read per distinct word touched: the first byte, and every
  // even byte address reached after it.
  function automatic int exp_reads(input logic [15:0] a, input int n);
    int r;
    logic [15:0] b;
    r = 0;
    for (int i = 0; i < n; i++) begin
      b = a + 16'(i);
      if (i == 0 || b[0] == 1'b0) r++;
    end
    return r;
  endfunction

  // Cycle of the done pulse with m_ready held high (start in cycle 0).
  function automatic int exp_done_cyc(input logic [15:0] a, input int n);
    return 1 + exp_reads(a, n) * (RL + 1) + n;
  endfunction

  // Index of first difference between got_q and exp_q, -1 if identical.
  function automatic int q_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Runs one transfer and records what the DUT did; no checking here.
  task automatic xfer(input logic [15:0] a, input logic [15:0] n,
                      input int stall_idx, input int stall_len,
                      input bit rnd_ready, input bit poke_start);
    int cyc, stalled;
    bit prev_stall, in_read;
    logic [7:0] prev_data;
    logic [12:0] prev_ma;
    got_q.delete();
    r_first_v = -1; r_done_n = 0; r_done_c = -1; r_last_hs = -1;
    r_reads = 0; r_hold_err = 0;
    stalled = 0; prev_stall = 1'b0; in_read = 1'b0;
    prev_data = 8'h00; prev_ma = 13'h0;
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = a; bus.byte_count = n; bus.m_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      bus.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_valid && got_q.size() == stall_idx && stalled < stall_len) begin
        bus.m_ready = 1'b0;
        stalled++;
      end
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data ||
                         bus.mem_address !== prev_ma)) r_hold_err++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_ma    = bus.mem_address;
      if (bus.m_valid && r_first_v < 0) r_first_v = cyc;
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back(bus.m_data);
        r_last_hs = cyc;
      end
      if (bus.busy && !bus.m_valid && !bus.done) begin
        if (!in_read) r_reads++;
        in_read = 1'b1;
      end else begin
        in_read = 1'b0;
      end
      if (bus.done) begin
        r_done_n++;
        r_done_c = cyc;
      end
      bus.start = 1'b0;
      if (poke_start && r_done_n == 0) begin
        bus.start      = 1'($urandom_range(0, 1));
        bus.start_addr = 16'($urandom);
        bus.byte_count = 16'($urandom);
      end
      if (r_done_n > 0 && cyc > r_done_c + 2) break;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.m_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.m_valid); end
    n_tests++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", bus.m_data); end
    n_tests++; if (bus.mem_address !== 13'h0) begin n_fail++; $display("FAIL reset_mem_address got %h want 0000", bus.mem_address); end
  endtask

  task automatic test_basic();
    int d;
    mem[0][0] = 16'hBEEF; mem[0][1] = 16'h1234;
    xfer(16'h0000, 16'd4, -1, 0, 1'b0, 1'b0);
    exp_q = '{8'hEF, 8'hBE, 8'h34, 8'h12};
    d = q_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL basic_bytes idx %0d got %h want %h (sizes %0d/%0d)", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size(), exp_q.size()); end
    n_tests++; if (r_first_v !== RL + 2) begin n_fail++; $display("FAIL basic_first_valid got %0d want %0d", r_first_v, RL + 2); end
    n_tests++; if (r_done_n !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", r_done_n); end
    n_tests++; if (r_done_c !== r_last_hs + 1) begin n_fail++; $display("FAIL basic_done_cycle got %0d want %0d", r_done_c, r_last_hs + 1); end
    n_tests++; if (r_done_c !== exp_done_cyc(16'h0000, 4)) begin n_fail++; $display("FAIL basic_throughput got %0d want %0d", r_done_c, exp_done_cyc(16'h0000, 4)); end
    n_tests++; if (r_reads !== 2) begin n_fail++; $display("FAIL basic_reads got %0d want 2", r_reads); end
  endtask

  task automatic test_bank_cross();
    int d;
    mem[1][0] = 16'hA55A; mem[1][1] = 16'h00C3;
    xfer(16'h4001, 16'd2, -1, 0, 1'b0, 1'b0);
    exp_q = '{8'hA5, 8'hC3};
    d = q_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL bank1_bytes idx %0d got %h want %h (sizes %0d/%0d)", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size(), exp_q.size()); end
    n_tests++; if (r_reads !== 2) begin n_fail++; $display("FAIL bank1_reads got %0d want 2", r_reads); end
  endtask

  task automatic test_wrap();
    int d;
    mem[3][13'h1FFF] = 16'h7700; mem[0][0] = 16'h0011;
    xfer(16'hFFFF, 16'd2, -1, 0, 1'b0, 1'b0);
    exp_q = '{8'h77, 8'h11};
    d = q_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL wrap_bytes idx %0d got %h want %h (sizes %0d/%0d)", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size(), exp_q.size()); end
    n_tests++; if (r_done_c !== exp_done_cyc(16'hFFFF, 2)) begin n_fail++; $display("FAIL wrap_done_cycle got %0d want %0d", r_done_c, exp_done_cyc(16'hFFFF, 2)); end
  endtask

  task automatic test_stall();
    int d;
    mem[0][0] = 16'hBEEF; mem[0][1] = 16'h1234;
    xfer(16'h0000, 16'd4, 1, 5, 1'b0, 1'b0);
    exp_q = '{8'hEF, 8'hBE, 8'h34, 8'h12};
    d = q_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL stall_bytes idx %0d got %h want %h (sizes %0d/%0d)", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size(), exp_q.size()); end
    n_tests++; if (r_hold_err !== 0) begin n_fail++; $display("FAIL stall_hold got %0d violations want 0", r_hold_err); end
    n_tests++; if (r_done_c !== exp_done_cyc(16'h0000, 4) + 5) begin n_fail++; $display("FAIL stall_done_cycle got %0d want %0d", r_done_c, exp_done_cyc(16'h0000, 4) + 5); end
  endtask

  task automatic test_empty_and_ignore();
    int d;
    xfer(16'h1234, 16'd0, -1, 0, 1'b0, 1'b0);
    n_tests++; if (r_done_c !== 1) begin n_fail++; $display("FAIL empty_done_cycle got %0d want 1", r_done_c); end
    n_tests++; if (r_done_n !== 1) begin n_fail++; $display("FAIL empty_done_count got %0d want 1", r_done_n); end
    n_tests++; if (r_first_v !== -1) begin n_fail++; $display("FAIL empty_valid got first valid %0d want none", r_first_v); end
    mem[0][0] = 16'hBEEF; mem[0][1] = 16'h1234;
    xfer(16'h0000, 16'd4, -1, 0, 1'b0, 1'b1);
    build_exp(16'h0000, 4);
    d = q_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL ignore_bytes idx %0d got %h want %h (sizes %0d/%0d)", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size(), exp_q.size()); end
    n_tests++; if (r_done_n !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", r_done_n); end
    n_tests++; if (r_done_c !== exp_done_cyc(16'h0000, 4)) begin n_fail++; $display("FAIL ignore_done_cycle got %0d want %0d", r_done_c, exp_done_cyc(16'h0000, 4)); end
  endtask

  task automatic test_mid_reset();
    int d;
    bit seen;
    mem[0][0] = 16'hBEEF; mem[0][1] = 16'h1234;
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = 16'h0000; bus.byte_count = 16'd4; bus.m_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.m_valid) seen = 1'b1;
      else @(negedge clk);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL midrst_reach_send got no m_valid want m_valid within 20 cycles"); end
    rst = 1'b1;
    #1;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus.m_valid); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", bus.done); end
    @(negedge clk);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    xfer(16'h0000, 16'd1, -1, 0, 1'b0, 1'b0);
    exp_q = '{8'hEF};
    d = q_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL midrst_restart idx %0d got %h want %h (sizes %0d/%0d)", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size(), exp_q.size()); end
    n_tests++; if (r_done_n !== 1) begin n_fail++; $display("FAIL midrst_done_count got %0d want 1", r_done_n); end
  endtask

  task automatic test_random();
    int d, n;
    logic [15:0] a;
    for (int t = 0; t < 20; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
      n = $urandom_range(1, 12);
      xfer(a, 16'(n), -1, 0, 1'b1, 1'b0);
      build_exp(a, n);
      d = q_diff();
      n_tests++; if (d >= 0) begin n_fail++; $display("FAIL random_bytes t%0d addr %h cnt %0d idx %0d got %h want %h", t, a, n, d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
      n_tests++; if (r_hold_err !== 0) begin n_fail++; $display("FAIL random_hold t%0d got %0d violations want 0", t, r_hold_err); end
      n_tests++; if (r_done_n !== 1 || r_done_c !== r_last_hs + 1) begin n_fail++; $display("FAIL random_done t%0d got count %0d cycle %0d want count 1 cycle %0d", t, r_done_n, r_done_c, r_last_hs + 1); end
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 8192; w++) mem[b][w] = 16'($urandom);
    bus.start = 1'b0;
    bus.start_addr = 16'h0000;
    bus.byte_count = 16'h0000;
    bus.m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_basic();
    test_bank_cross();
    test_wrap();
    test_stall();
    test_empty_and_ignore();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
